// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter.
// Several requesters share one register-file write port through a round-robin
// arbiter. A clear pulse zero-fills registers 1..NumRegs-1, one per cycle.
module regfile_wb_arbiter #(
    parameter int NumReq       = 3,
    parameter int NumRegs      = 32,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 5
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumReq-1:0]              req_valid_i,
    output logic [NumReq-1:0]              req_ready_o,
    input  logic [NumReq*AddressWidth-1:0] req_addr_i,
    input  logic [NumReq*DataWidth-1:0]    req_data_i,
    input  logic                           clear_i,
    output logic                           clear_busy_o,
    output logic                           wr_en_o,
    output logic [AddressWidth-1:0]        wr_addr_o,
    output logic [DataWidth-1:0]           wr_data_o,
    output logic [NumReq-1:0]              grant_o
);

    localparam int PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [AddressWidth-1:0] LastAddr  = AddressWidth'(NumRegs - 1);
    localparam logic [AddressWidth-1:0] FirstAddr = AddressWidth'(1);
    localparam logic [PtrWidth-1:0]     LastPtr   = PtrWidth'(NumReq - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state_q, state_d;
    logic [PtrWidth-1:0]     ptr_q, ptr_d;
    logic [AddressWidth-1:0] cnt_q, cnt_d;
    logic                    busy_q;

    logic                    sel_found;
    logic [PtrWidth-1:0]     sel_idx;
    logic [NumReq-1:0]       sel_onehot;
    logic [AddressWidth-1:0] sel_addr;
    logic [DataWidth-1:0]    sel_data;
    logic                    accept;
    logic                    clear_write;

    // Round-robin pick: first pass covers requesters at or above the pointer,
    // second pass wraps to those below it, which equals a search from P mod NumReq.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        sel_addr   = '0;
        sel_data   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!sel_found && (k >= 32'(ptr_q)) && req_valid_i[k]) begin
                sel_found     = 1'b1;
                sel_idx       = PtrWidth'(k);
                sel_onehot    = '0;
                sel_onehot[k] = 1'b1;
                sel_addr      = req_addr_i[k*AddressWidth +: AddressWidth];
                sel_data      = req_data_i[k*DataWidth +: DataWidth];
            end
        end
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!sel_found && (k < 32'(ptr_q)) && req_valid_i[k]) begin
                sel_found     = 1'b1;
                sel_idx       = PtrWidth'(k);
                sel_onehot    = '0;
                sel_onehot[k] = 1'b1;
                sel_addr      = req_addr_i[k*AddressWidth +: AddressWidth];
                sel_data      = req_data_i[k*DataWidth +: DataWidth];
            end
        end
    end

    // Next-state, pointer/counter update and handshake generation.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        req_ready_o = '0;
        accept      = 1'b0;
        clear_write = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d = CLEAR;
                end else if (sel_found) begin
                    accept      = 1'b1;
                    req_ready_o = sel_onehot;
                    ptr_d       = (sel_idx == LastPtr) ? '0 : sel_idx + 1'b1;
                end
            end
            CLEAR: begin
                clear_write = 1'b1;
                if (cnt_q == LastAddr) begin
                    cnt_d   = FirstAddr;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            req_ready_o = '0;
            accept      = 1'b0;
            clear_write = 1'b0;
        end
    end

    // FSM state, round-robin pointer and clear counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= FirstAddr;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered write port; address/data only move on an actual write so that
    // accepted address-0 requests leave them holding like idle cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            grant_o   <= '0;
            busy_q    <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;
            grant_o <= '0;
            busy_q  <= (state_q == CLEAR) || (state_d == CLEAR);
            if (clear_write) begin
                wr_en_o   <= 1'b1;
                wr_addr_o <= cnt_q;
                wr_data_o <= '0;
            end else if (accept && (sel_addr != '0)) begin
                wr_en_o   <= 1'b1;
                wr_addr_o <= sel_addr;
                wr_data_o <= sel_data;
                grant_o   <= sel_onehot;
            end
        end
    end

    assign clear_busy_o = busy_q & ~rst_i;

endmodule
